// File: rtl/cnn16_pkg.sv
//------------------------------------------------------------------------------
// Module : cnn16_pkg
// Brief  : Shared constants and the state encoding for the CNN_16 program loader.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cnn16_pkg;

  localparam int AW_DEF        = 12;
  localparam int DW_DEF        = 16;
  localparam int MAX_WORDS_DEF = 4096;

  // First byte of every 16-bit field on the wire is the high byte.
  localparam bit BIG_ENDIAN = 1'b1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_A_HI  = 4'd1;
  localparam logic [3:0] S_A_LO  = 4'd2;
  localparam logic [3:0] S_C_HI  = 4'd3;
  localparam logic [3:0] S_C_LO  = 4'd4;
  localparam logic [3:0] S_D_HI  = 4'd5;
  localparam logic [3:0] S_D_LO  = 4'd6;
  localparam logic [3:0] S_WRITE = 4'd7;
  localparam logic [3:0] S_K_HI  = 4'd8;
  localparam logic [3:0] S_K_LO  = 4'd9;
  localparam logic [3:0] S_FIN   = 4'd10;

  typedef enum logic [3:0] {
    ST_IDLE  = S_IDLE,
    ST_A_HI  = S_A_HI,
    ST_A_LO  = S_A_LO,
    ST_C_HI  = S_C_HI,
    ST_C_LO  = S_C_LO,
    ST_D_HI  = S_D_HI,
    ST_D_LO  = S_D_LO,
    ST_WRITE = S_WRITE,
    ST_K_HI  = S_K_HI,
    ST_K_LO  = S_K_LO,
    ST_FIN   = S_FIN
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cnn16_word_assembler.sv
//------------------------------------------------------------------------------
// Module : cnn16_word_assembler
// Brief  : Joins a hi/lo byte pair into a 16-bit word; word_valid marks the lo byte.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cnn16_word_assembler
  import cnn16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_en,
  input  logic        lo_en,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        word_valid
);

  logic [7:0] first_byte;

  always_ff @(posedge clk) begin
    if (rst)
      first_byte <= 8'h00;
    else if (hi_en)
      first_byte <= byte_in;
  end

  // The word is presented in the same cycle the second byte is accepted.
  assign word       = BIG_ENDIAN ? {first_byte, byte_in} : {byte_in, first_byte};
  assign word_valid = lo_en;

endmodule

`default_nettype wire

// File: rtl/cnn16_prog_loader.sv
//------------------------------------------------------------------------------
// Module : cnn16_prog_loader
// Brief  : Byte-stream to CNN_16 program-RAM loader; holds the CPU in reset while
//          loading. Optional checksum trailer: CNN16_LOADER_CHECKSUM_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cnn16_prog_loader
  import cnn16_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic          clkn,
  input  logic          rstn,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  output logic          sel_out,
  output logic          we_out,
  output logic [AW-1:0] adr_out,
  output logic [DW-1:0] data_out,
  output logic          cpu_rst_out,
  output logic          done,
  output logic          err
);

  localparam int          RW       = $clog2(MAX_WORDS) + 1;
  localparam logic [16:0] MAX_W17  = 17'(MAX_WORDS);
`ifdef CNN16_LOADER_CHECKSUM_EN
  localparam state_t      ST_AFTER = ST_K_HI;
`else
  localparam state_t      ST_AFTER = ST_FIN;
`endif

  state_t        state, state_nxt;
  logic          accept, hi_en, lo_en;
  logic [15:0]   word;
  logic          word_valid;
  logic          count_over, count_zero;
  logic [AW-1:0] adr_ptr;
  logic [RW-1:0] remaining;

  assign accept = in_valid & in_ready;
  assign hi_en  = accept & (state == ST_A_HI || state == ST_C_HI ||
                            state == ST_D_HI || state == ST_K_HI);
  assign lo_en  = accept & (state == ST_A_LO || state == ST_C_LO ||
                            state == ST_D_LO || state == ST_K_LO);

  cnn16_word_assembler u_asm (
    .clk        (clkn),
    .rst        (rstn),
    .hi_en      (hi_en),
    .lo_en      (lo_en),
    .byte_in    (in_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  assign count_over = {1'b0, word} > MAX_W17;
  assign count_zero = (word == 16'h0000);

  always_ff @(posedge clkn) begin
    if (rstn) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    sel_out     = (state != ST_IDLE);
    cpu_rst_out = (state != ST_IDLE);
    we_out      = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_A_HI;
      ST_A_HI:  begin in_ready = 1'b1; if (accept) state_nxt = ST_A_LO; end
      ST_A_LO:  begin in_ready = 1'b1; if (accept) state_nxt = ST_C_HI; end
      ST_C_HI:  begin in_ready = 1'b1; if (accept) state_nxt = ST_C_LO; end
      ST_C_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if (count_over)      state_nxt = ST_IDLE;
          else if (count_zero) state_nxt = ST_AFTER;
          else                 state_nxt = ST_D_HI;
        end
      end
      ST_D_HI:  begin in_ready = 1'b1; if (accept) state_nxt = ST_D_LO; end
      ST_D_LO:  begin in_ready = 1'b1; if (accept) state_nxt = ST_WRITE; end
      ST_WRITE: begin
        we_out    = 1'b1;
        state_nxt = (remaining == RW'(1)) ? ST_AFTER : ST_D_HI;
      end
`ifdef CNN16_LOADER_CHECKSUM_EN
      ST_K_HI:  begin in_ready = 1'b1; if (accept) state_nxt = ST_K_LO; end
      ST_K_LO:  begin in_ready = 1'b1; if (accept) state_nxt = ST_FIN; end
`endif
      ST_FIN: begin
        done      = ~err;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

`ifdef CNN16_LOADER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  always_ff @(posedge clkn) begin
    if (rstn) begin
      adr_ptr   <= '0;
      remaining <= '0;
      adr_out   <= '0;
      data_out  <= '0;
      err       <= 1'b0;
`ifdef CNN16_LOADER_CHECKSUM_EN
      csum      <= 16'h0000;
`endif
    end else begin
      if (state == ST_IDLE && start) begin
        err <= 1'b0;
`ifdef CNN16_LOADER_CHECKSUM_EN
        csum <= 16'h0000;
`endif
      end
      if (word_valid) begin
        case (state)
          ST_A_LO: adr_ptr <= word[AW-1:0];
          ST_C_LO: begin
            remaining <= word[RW-1:0];
            if (count_over) err <= 1'b1;
          end
          ST_D_LO: begin
            adr_out  <= adr_ptr;
            data_out <= DW'(word);
`ifdef CNN16_LOADER_CHECKSUM_EN
            csum     <= csum + word;
`endif
          end
`ifdef CNN16_LOADER_CHECKSUM_EN
          ST_K_LO: if (word != csum) err <= 1'b1;
`endif
          default: ;
        endcase
      end
      // Pointer wraps naturally at 2**AW.
      if (state == ST_WRITE) begin
        adr_ptr   <= adr_ptr + AW'(1);
        remaining <= remaining - RW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cnn16_prog_loader.sv
//------------------------------------------------------------------------------
// Module : tb_cnn16_prog_loader
// Brief  : Directed self-checking bench for cnn16_prog_loader.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cnn16_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready, sel_out, we_out, cpu_rst_out, done, err;
  logic [11:0] adr_out;
  logic [15:0] data_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [27:0] wq[$];
  logic [7:0]  seq[$];

  always #5 clk = ~clk;

  cnn16_prog_loader dut (
    .clkn        (clk),
    .rstn        (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .sel_out     (sel_out),
    .we_out      (we_out),
    .adr_out     (adr_out),
    .data_out    (data_out),
    .cpu_rst_out (cpu_rst_out),
    .done        (done),
    .err         (err)
  );

  // Capture every write strobe and done pulse away from the active edge.
  always @(negedge clk) begin
    if (we_out) wq.push_back({adr_out, data_out});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_all(input int gap);
    foreach (seq[i]) begin
      send(seq[i]);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sel_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, sel_out}, 32'd0);
  endtask

  task automatic new_session();
    wq.delete();
    done_cnt = 0;
    pulse_start();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ctl", {26'd0, in_ready, sel_out, we_out, cpu_rst_out, done, err}, 32'd0);
    check("reset_adr", {20'd0, adr_out}, 32'd0);
    check("reset_data", {16'd0, data_out}, 32'd0);

    // Basic three-word load
    new_session();
    check("basic_own", {30'd0, sel_out, cpu_rst_out}, 32'd3);
    seq = '{8'h00, 8'h10, 8'h00, 8'h03, 8'h12, 8'h34};
    send_all(0);
    check("lat_we", {31'd0, we_out}, 32'd1);
    check("lat_adr", {20'd0, adr_out}, 32'h010);
    check("lat_data", {16'd0, data_out}, 32'h1234);
    seq = '{8'h56, 8'h78, 8'h9A, 8'hBC};
    send_all(0);
`ifdef CNN16_LOADER_CHECKSUM_EN
    seq = '{8'h03, 8'h68};
    send_all(0);
`endif
    wait_idle();
    check("basic_nwr", wq.size(), 32'd3);
    if (wq.size() == 3) begin
      check("basic_w0", {4'd0, wq[0]}, {4'd0, 12'h010, 16'h1234});
      check("basic_w1", {4'd0, wq[1]}, {4'd0, 12'h011, 16'h5678});
      check("basic_w2", {4'd0, wq[2]}, {4'd0, 12'h012, 16'h9ABC});
    end
    check("basic_done", done_cnt, 32'd1);
    check("basic_rel", {30'd0, sel_out, cpu_rst_out}, 32'd0);

    // Address wrap
    new_session();
    seq = '{8'h0F, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hAA, 8'hBB, 8'hBB};
    send_all(0);
`ifdef CNN16_LOADER_CHECKSUM_EN
    seq = '{8'h66, 8'h65};
    send_all(0);
`endif
    wait_idle();
    check("wrap_nwr", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      check("wrap_w0", {4'd0, wq[0]}, {4'd0, 12'hFFF, 16'hAAAA});
      check("wrap_w1", {4'd0, wq[1]}, {4'd0, 12'h000, 16'hBBBB});
    end
    check("wrap_done", done_cnt, 32'd1);

    // Zero count
    new_session();
    seq = '{8'h00, 8'h40, 8'h00, 8'h00};
    send_all(0);
`ifdef CNN16_LOADER_CHECKSUM_EN
    seq = '{8'h00, 8'h00};
    send_all(0);
`endif
    wait_idle();
    check("zero_nwr", wq.size(), 32'd0);
    check("zero_done", done_cnt, 32'd1);
    check("zero_err", {31'd0, err}, 32'd0);

    // Count overflow
    new_session();
    seq = '{8'h00, 8'h00, 8'h10, 8'h01};
    send_all(0);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_idle", {29'd0, sel_out, cpu_rst_out, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("ovf_nwr", wq.size(), 32'd0);
    check("ovf_done", done_cnt, 32'd0);
    check("ovf_sticky", {31'd0, err}, 32'd1);

    // Backpressure: gaps between bytes, stray start mid-session
    new_session();
    check("start_clr_err", {31'd0, err}, 32'd0);
    seq = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02};
    send_all(2);
    pulse_start();
    seq = '{8'h03, 8'h04};
    send_all(1);
`ifdef CNN16_LOADER_CHECKSUM_EN
    seq = '{8'h04, 8'h06};
    send_all(1);
`endif
    wait_idle();
    check("bp_nwr", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      check("bp_w0", {4'd0, wq[0]}, {4'd0, 12'h100, 16'h0102});
      check("bp_w1", {4'd0, wq[1]}, {4'd0, 12'h101, 16'h0304});
    end
    check("bp_done", done_cnt, 32'd1);

    // Reset in the middle of a data word
    new_session();
    seq = '{8'h00, 8'h20, 8'h00, 8'h02, 8'hAB};
    send_all(0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ctl", {26'd0, in_ready, sel_out, we_out, cpu_rst_out, done, err}, 32'd0);
    check("mid_rst_dat", {4'd0, adr_out, data_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    new_session();
    seq = '{8'h00, 8'h20, 8'h00, 8'h01, 8'hCA, 8'hFE};
    send_all(0);
`ifdef CNN16_LOADER_CHECKSUM_EN
    seq = '{8'hCA, 8'hFE};
    send_all(0);
`endif
    wait_idle();
    check("rel_nwr", wq.size(), 32'd1);
    if (wq.size() == 1)
      check("rel_w0", {4'd0, wq[0]}, {4'd0, 12'h020, 16'hCAFE});
    check("rel_done", done_cnt, 32'd1);

`ifdef CNN16_LOADER_CHECKSUM_EN
    new_session();
    seq = '{8'h00, 8'h30, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    send_all(0);
    wait_idle();
    check("ck_ok_done", done_cnt, 32'd1);
    check("ck_ok_err", {31'd0, err}, 32'd0);

    new_session();
    seq = '{8'h00, 8'h30, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04};
    send_all(0);
    wait_idle();
    check("ck_bad_done", done_cnt, 32'd0);
    check("ck_bad_err", {31'd0, err}, 32'd1);
    check("ck_bad_nwr", wq.size(), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
